regfile_write_arbiter: RTL
==========================

# regfile_write_arbiter

Shares the register file's single write port (`RegWrite`, `write_reg`, `write_data`) between N writeback requesters such as the ALU, load unit and mult/div unit. Each requester has a one-entry holding buffer with a valid/ready handshake. A round-robin arbiter issues at most one buffered write per clock as a registered write-port command. A pending-destination bitmap is exported for hazard stall logic.

## Interface
- `N_REQ`, default 3: number of requesters, 2..8.
- `DATA_W`, default 32: write data width.
- `ADDR_W`, default 5: register index width. The bitmap width is 2**ADDR_W.
- `clk`, input, 1: system clock. All state changes on posedge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req_valid`, input, N_REQ: per-requester write request.
- `req_reg`, input, N_REQ*ADDR_W: destination index. Requester i uses bits `[i*ADDR_W +: ADDR_W]`.
- `req_data`, input, N_REQ*DATA_W: write data. Requester i uses bits `[i*DATA_W +: DATA_W]`.
- `req_ready`, output, N_REQ: the buffer can accept this cycle.
- `RegWrite`, output, 1: registered write enable to the register file.
- `write_reg`, output, ADDR_W: registered write index.
- `write_data`, output, DATA_W: registered write data.
- `pending_mask`, output, 2**ADDR_W: destinations that are buffered or on the write port.

## Operation
- **Buffers.** Per requester: `full[i]`, `buf_reg[i]`, `buf_data[i]`.
- **Accept.** Requester i is accepted when `req_valid[i] && req_ready[i]` at posedge. Accept sets `full[i]` and captures the index and data.
- **Ready.** `req_ready[i] = !full[i] | grant[i]`, so a buffer being drained can refill in the same cycle. `req_ready` is forced to 0 while `rst_n` is low.
- **Writes to register 0.** These are accepted normally, then discarded: `full` is not set and no port slot is used.
- **Grant.** `grant` is combinational and one-hot among the `full` buffers.
  - Search starts at pointer `rr_ptr` and goes upward, wrapping modulo N_REQ.
  - On a grant to i, `rr_ptr` becomes (i+1) mod N_REQ at posedge.
  - With no grant, `rr_ptr` holds.
- **Issue.** On a grant to i at posedge:
  - `RegWrite` is set to 1.
  - `write_reg` and `write_data` load from buffer i.
  - `full[i]` clears, unless buffer i accepts a new request in the same cycle.
- **Idle.** With no grant, `RegWrite` is set to 0. `write_reg` and `write_data` hold their last values.
- **`pending_mask`.** OR of the decoded `buf_reg` of every full buffer, plus the decode of `write_reg` while `RegWrite` = 1. Bit 0 is always 0. The mask is combinational from registered state.
- **Ordering.** Writes from one requester issue in acceptance order. No order is guaranteed across requesters. Producers must not hold two in-flight writes to the same register; stall logic uses `pending_mask` to enforce this.
- **Reset values.** Every buffer empty, `RegWrite` = 0, `write_reg` = 0, `write_data` = 0, `rr_ptr` = 0, `pending_mask` = 0.

## Timing
- **Latency.** Accept at posedge T. Earliest issue is at posedge T+1, with `RegWrite` high for the cycle after T+1. The register file commits on the negedge inside that cycle.
- **Throughput.** One write per clock on aggregate. Each requester sustains one write per clock when it is the only contender.
- **Fairness.** With N full buffers contending continuously, each is granted within N cycles.
- **Simultaneous drain and accept on buffer i.** The old entry issues, the new entry is stored, and `full[i]` stays 1.
- **Reset mid-operation.** Asynchronous `rst_n` low immediately clears all buffers and `RegWrite`. Buffered writes are lost, and no partial write is issued after release.
- **Combinational paths.** None from `req_*` inputs to `RegWrite`, `write_reg`, `write_data` or `pending_mask`. `req_ready` depends only on state.

## Configuration
- **`RF_ARB_FIXED_PRIO_EN` defined.** Arbitration is fixed priority: the lowest-index full buffer wins. `rr_ptr` is not implemented. Starvation of high-index requesters is permitted.
- **`RF_ARB_FIXED_PRIO_EN` undefined (default).** Round-robin as described in Operation.

## Test plan
- **Reset.** Assert `rst_n` = 0 mid-run with buffers 0 and 2 full. Required: `RegWrite` = 0, `pending_mask` = 0 and `req_ready` = 0 during reset. After release: `req_ready` = 3'b111 and no writes issue.
- **Single write.** Requester 1 sends reg 3, data 32'hABCDEF12 at edge T. Required: `RegWrite` = 1, `write_reg` = 3, `write_data` = 32'hABCDEF12 for exactly the cycle after T+1. `pending_mask` bit 3 is set from T until that cycle ends.
- **Contention.** All three requesters hold valid continuously, targeting regs 4, 5 and 6. Required: grant order 0,1,2,0,1,2…, one write per cycle, and every `req_ready` toggling so that one write per requester per 3 cycles is accepted. With `RF_ARB_FIXED_PRIO_EN` defined: only reg 4 issues.
- **Register 0.** Requester 2 writes reg 0, data 32'hFFFFFFFF. Required: accepted (`req_ready` = 1), `RegWrite` never asserts, `pending_mask` stays 0.
- **Drain and refill.** Requester 0 streams regs 7, 8, 9 on consecutive cycles with others idle. Required: `req_ready[0]` stays 1 and writes issue for 7, 8, 9 on three consecutive cycles.
- **Per-requester order.** Requester 1 issues reg 10 then reg 11 while requester 0 competes. Required: reg 10 is written before reg 11.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: one-entry buffer per requester, one registered write per clock.
// Define RF_ARB_FIXED_PRIO_EN for fixed lowest-index priority; round-robin otherwise.
module regfile_write_arbiter #(
    parameter int N_REQ  = 3,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*ADDR_W-1:0]  req_reg,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     RegWrite,
    output logic [ADDR_W-1:0]        write_reg,
    output logic [DATA_W-1:0]        write_data,
    output logic [2**ADDR_W-1:0]     pending_mask
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]  full_q, full_d;
    logic [ADDR_W-1:0] buf_reg_q  [N_REQ];
    logic [ADDR_W-1:0] buf_reg_d  [N_REQ];
    logic [DATA_W-1:0] buf_data_q [N_REQ];
    logic [DATA_W-1:0] buf_data_d [N_REQ];

    logic              reg_write_q, reg_write_d;
    logic [ADDR_W-1:0] write_reg_q, write_reg_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;

    logic [N_REQ-1:0]  grant;
    logic [N_REQ-1:0]  accept;
    logic              any_grant;
    logic [PTR_W-1:0]  grant_idx;

`ifndef RF_ARB_FIXED_PRIO_EN
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PTR_W:0]    cand;

    // Search upward from rr_ptr, wrapping; one extra bit keeps ptr+k from overflowing before the wrap.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(N_REQ)) begin
                cand = cand - (PTR_W+1)'(N_REQ);
            end
            if (!any_grant && full_q[cand[PTR_W-1:0]]) begin
                any_grant = 1'b1;
                grant_idx = cand[PTR_W-1:0];
            end
        end
        if (any_grant) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (any_grant) begin
            rr_ptr_d = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!any_grant && full_q[k]) begin
                any_grant = 1'b1;
                grant_idx = PTR_W'(k);
            end
        end
        if (any_grant) begin
            grant[grant_idx] = 1'b1;
        end
    end
`endif

    // A buffer being drained this cycle may refill in the same cycle.
    assign req_ready = rst_n ? (~full_q | grant) : '0;
    assign accept    = req_valid & req_ready;

    // Writes to register 0 are accepted but never occupy the buffer.
    always_comb begin
        full_d     = full_q;
        buf_reg_d  = buf_reg_q;
        buf_data_d = buf_data_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                full_d[i] = 1'b0;
            end
            if (accept[i]) begin
                full_d[i]     = (req_reg[i*ADDR_W +: ADDR_W] != '0);
                buf_reg_d[i]  = req_reg[i*ADDR_W +: ADDR_W];
                buf_data_d[i] = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        reg_write_d  = any_grant;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        if (any_grant) begin
            write_reg_d  = buf_reg_q[grant_idx];
            write_data_d = buf_data_q[grant_idx];
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (full_q[i]) begin
                pending_mask[buf_reg_q[i]] = 1'b1;
            end
        end
        if (reg_write_q) begin
            pending_mask[write_reg_q] = 1'b1;
        end
        pending_mask[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q       <= '0;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                buf_reg_q[i]  <= '0;
                buf_data_q[i] <= '0;
            end
        end else begin
            full_q       <= full_d;
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            buf_reg_q    <= buf_reg_d;
            buf_data_q   <= buf_data_d;
        end
    end

    assign RegWrite   = reg_write_q;
    assign write_reg  = write_reg_q;
    assign write_data = write_data_q;

endmodule
